// File: rtl/half_period_toggle_ctrl.sv
// Burst/continuous square-wave generator: each output level lasts hp_reg cycles, first rise hp cycles after start.
// Config is accepted only in IDLE (cfg_ready); stop ends the run on the next low level so the final period is never truncated.
module half_period_toggle_ctrl #(
   parameter int CNT_W   = 16,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CNT_W-1:0]   cfg_half_period,
   input  logic [BURST_W-1:0] cfg_burst,
   input  logic               start,
   input  logic               stop,
   output logic               tog_out,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_hp;
   logic [CNT_W-1:0]   w_hp_new;
   logic [CNT_W-1:0]   w_hp_sel;
   logic [BURST_W-1:0] r_burst;
   logic [BURST_W-1:0] r_pcnt;
   logic [BURST_W-1:0] w_pcnt_inc;
   logic               r_tog;
   logic               r_done;
   logic               w_cfg_acc;
   logic               w_start;
   logic               w_tick;
   logic               w_fall;
   logic               w_burst_end;
   logic               w_finish;

   assign w_cfg_acc   = cfg_valid && (r_state == ST_IDLE);
   assign w_start     = start && (r_state == ST_IDLE);
   // A zero half-period is clamped to 1 so the counter reload never underflows.
   assign w_hp_new    = (cfg_half_period == '0) ? CNT_W'(1) : cfg_half_period;
   assign w_hp_sel    = w_cfg_acc ? w_hp_new : r_hp;
   assign w_tick      = (r_state != ST_IDLE) && (r_cnt == '0);
   assign w_fall      = w_tick && r_tog;
   assign w_pcnt_inc  = r_pcnt + BURST_W'(1);
   assign w_burst_end = w_fall && (r_burst != '0) && (w_pcnt_inc == r_burst);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_finish    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // A stop landing on a falling edge or a low level completes the run immediately.
            if (w_burst_end || (w_fall && stop) || (stop && !r_tog)) begin
               w_state_nxt = ST_IDLE;
               w_finish    = 1'b1;
            end else if (stop) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_fall) begin
               w_state_nxt = ST_IDLE;
               w_finish    = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_hp    <= CNT_W'(1);
         r_burst <= '0;
         r_pcnt  <= '0;
         r_tog   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_cfg_acc) begin
            r_hp    <= w_hp_new;
            r_burst <= cfg_burst;
         end
         if (w_start) begin
            r_cnt  <= w_hp_sel - CNT_W'(1);
            r_tog  <= 1'b0;
            r_pcnt <= '0;
         end else if (w_finish) begin
            r_cnt <= '0;
            r_tog <= 1'b0;
         end else if (r_state != ST_IDLE) begin
            if (w_tick) begin
               r_tog <= ~r_tog;
               r_cnt <= r_hp - CNT_W'(1);
               if (r_tog) begin
                  r_pcnt <= w_pcnt_inc;
               end
            end else begin
               r_cnt <= r_cnt - CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      cfg_ready = (r_state == ST_IDLE);
      busy      = (r_state != ST_IDLE);
      tog_out   = r_tog;
      done      = r_done;
   end

endmodule

// File: tb/tb_half_period_toggle_ctrl.sv
// Scoreboard bench: per-cycle expected {tog_out, done, busy, cfg_ready} is pushed as stimulus is driven
// and popped for comparison one time unit after each rising edge.
module tb_half_period_toggle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [15:0] cfg_half_period;
   logic [7:0]  cfg_burst;
   logic        start;
   logic        stop;
   logic        tog_out;
   logic        busy;
   logic        done;

   int          checks = 0;
   int          errors = 0;
   logic [3:0]  exp_q[$];
   logic [3:0]  exp_v;
   bit          t, d, b;

   half_period_toggle_ctrl #(.CNT_W(16), .BURST_W(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_half_period (cfg_half_period),
      .cfg_burst       (cfg_burst),
      .start           (start),
      .stop            (stop),
      .tog_out         (tog_out),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic do_cfg(input logic [15:0] hp, input logic [7:0] burst);
      cfg_valid       = 1'b1;
      cfg_half_period = hp;
      cfg_burst       = burst;
      @(posedge clk);
      #1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      exp_q.push_back(4'b0001);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({tog_out, done, busy, cfg_ready} !== exp_v) begin
         errors++;
         $display("FAIL reset got %b want %b", {tog_out, done, busy, cfg_ready}, exp_v);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 3; n++) begin
         stop = (n == 0);
         exp_q.push_back(4'b0001);
         @(posedge clk);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if ({tog_out, done, busy, cfg_ready} !== exp_v) begin
            errors++;
            $display("FAIL idle_stop n=%0d got %b want %b", n, {tog_out, done, busy, cfg_ready}, exp_v);
         end
         @(negedge clk);
      end
      stop = 1'b0;
   endtask

   task automatic test_burst();
      do_cfg(16'd3, 8'd2);
      for (int n = 0; n < 15; n++) begin
         start = (n == 0) || (n == 4);
         t = ((n >= 3) && (n < 6)) || ((n >= 9) && (n < 12));
         d = (n == 12);
         b = (n < 12);
         exp_q.push_back({t, d, b, ~b});
         @(posedge clk);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if ({tog_out, done, busy, cfg_ready} !== exp_v) begin
            errors++;
            $display("FAIL burst n=%0d got %b want %b", n, {tog_out, done, busy, cfg_ready}, exp_v);
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_zero_hp();
      do_cfg(16'd0, 8'd1);
      for (int n = 0; n < 5; n++) begin
         start = (n == 0);
         t = (n == 1);
         d = (n == 2);
         b = (n < 2);
         exp_q.push_back({t, d, b, ~b});
         @(posedge clk);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if ({tog_out, done, busy, cfg_ready} !== exp_v) begin
            errors++;
            $display("FAIL zero_hp n=%0d got %b want %b", n, {tog_out, done, busy, cfg_ready}, exp_v);
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_stop_high();
      do_cfg(16'd4, 8'd0);
      for (int n = 0; n < 15; n++) begin
         start = (n == 0);
         stop  = (n == 5) || (n == 6);
         t = (n >= 4) && (n < 8);
         d = (n == 8);
         b = (n < 8);
         exp_q.push_back({t, d, b, ~b});
         @(posedge clk);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if ({tog_out, done, busy, cfg_ready} !== exp_v) begin
            errors++;
            $display("FAIL stop_high n=%0d got %b want %b", n, {tog_out, done, busy, cfg_ready}, exp_v);
         end
         @(negedge clk);
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic test_stop_low();
      do_cfg(16'd4, 8'd0);
      for (int n = 0; n < 9; n++) begin
         start = (n == 0);
         stop  = (n == 2);
         t = 1'b0;
         d = (n == 2);
         b = (n < 2);
         exp_q.push_back({t, d, b, ~b});
         @(posedge clk);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if ({tog_out, done, busy, cfg_ready} !== exp_v) begin
            errors++;
            $display("FAIL stop_low n=%0d got %b want %b", n, {tog_out, done, busy, cfg_ready}, exp_v);
         end
         @(negedge clk);
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic test_cfg_start();
      do_cfg(16'd2, 8'd1);
      for (int r = 0; r < 2; r++) begin
         for (int n = 0; n < 12; n++) begin
            start           = (n == 0);
            cfg_valid       = ((r == 0) && (n == 0)) || (n == 2);
            cfg_half_period = (n == 0) ? 16'd5 : 16'd2;
            cfg_burst       = (n == 0) ? 8'd1 : 8'd3;
            t = (n >= 5) && (n < 10);
            d = (n == 10);
            b = (n < 10);
            exp_q.push_back({t, d, b, ~b});
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if ({tog_out, done, busy, cfg_ready} !== exp_v) begin
               errors++;
               $display("FAIL cfg_start r=%0d n=%0d got %b want %b", r, n, {tog_out, done, busy, cfg_ready}, exp_v);
            end
            @(negedge clk);
         end
      end
      start     = 1'b0;
      cfg_valid = 1'b0;
   endtask

   task automatic test_continuous_wrap();
      do_cfg(16'd1, 8'd0);
      for (int n = 0; n < 604; n++) begin
         start = (n == 0);
         stop  = (n == 601);
         t = (n >= 1) && (n < 601) && (n % 2 == 1);
         d = (n == 601);
         b = (n < 601);
         exp_q.push_back({t, d, b, ~b});
         @(posedge clk);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if ({tog_out, done, busy, cfg_ready} !== exp_v) begin
            errors++;
            $display("FAIL wrap n=%0d got %b want %b", n, {tog_out, done, busy, cfg_ready}, exp_v);
         end
         @(negedge clk);
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic test_stop_burst_coincide();
      do_cfg(16'd2, 8'd1);
      for (int n = 0; n < 9; n++) begin
         start = (n == 0);
         stop  = (n == 4) || (n == 5);
         t = (n >= 2) && (n < 4);
         d = (n == 4);
         b = (n < 4);
         exp_q.push_back({t, d, b, ~b});
         @(posedge clk);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if ({tog_out, done, busy, cfg_ready} !== exp_v) begin
            errors++;
            $display("FAIL coincide n=%0d got %b want %b", n, {tog_out, done, busy, cfg_ready}, exp_v);
         end
         @(negedge clk);
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic test_reset_midrun();
      do_cfg(16'd3, 8'd0);
      for (int n = 0; n < 12; n++) begin
         start = (n == 0) || (n == 6);
         stop  = (n == 9);
         rst   = (n == 4);
         t = (n == 3) || (n == 7);
         d = (n == 9);
         b = (n < 4) || ((n >= 6) && (n < 9));
         exp_q.push_back({t, d, b, ~b});
         @(posedge clk);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if ({tog_out, done, busy, cfg_ready} !== exp_v) begin
            errors++;
            $display("FAIL reset_midrun n=%0d got %b want %b", n, {tog_out, done, busy, cfg_ready}, exp_v);
         end
         @(negedge clk);
      end
      start = 1'b0;
      stop  = 1'b0;
      rst   = 1'b0;
   endtask

   initial begin
      rst             = 1'b1;
      cfg_valid       = 1'b0;
      cfg_half_period = '0;
      cfg_burst       = '0;
      start           = 1'b0;
      stop            = 1'b0;
      test_reset();
      test_burst();
      test_zero_hp();
      test_stop_high();
      test_stop_low();
      test_cfg_start();
      test_continuous_wrap();
      test_stop_burst_coincide();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/half_period_toggle_ctrl.md
HALF_PERIOD_TOGGLE_CTRL -- requirements
Module: half_period_toggle_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the half-period counter width.
REQ-002 The block SHALL have parameter BURST_W, default 8, giving the burst-length width.
REQ-003 Port clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port cfg_valid, input, 1: configuration offer.
REQ-006 Port cfg_ready, output, 1: configuration accepted when cfg_valid && cfg_ready.
REQ-007 Port cfg_half_period, input, CNT_W: cycles per output level.
REQ-008 Port cfg_burst, input, BURST_W: number of full periods; 0 means continuous.
REQ-009 Port start, input, 1: begin toggling with the stored configuration.
REQ-010 Port stop, input, 1: request an orderly stop.
REQ-011 Port tog_out, output, 1: registered toggle waveform.
REQ-012 Port busy, output, 1: high in RUN and DRAIN.
REQ-013 Port done, output, 1: one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DRAIN; cfg_ready SHALL equal (state==IDLE).
REQ-015 On acceptance, hp_reg SHALL take max(cfg_half_period,1) and burst_reg SHALL take cfg_burst.
REQ-016 When cfg acceptance and start coincide in IDLE, the newly accepted configuration SHALL be the one used by that run.
REQ-017 start in IDLE SHALL take effect as follows: RUN entered, counter loaded with hp_reg-1, tog_out=0, period count cleared.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 stop in IDLE SHALL be ignored.
REQ-020 In RUN/DRAIN the counter SHALL decrement each cycle; at 0 the block SHALL invert tog_out and reload hp_reg-1.
REQ-021 Timing: the first tog_out rise SHALL be registered hp cycles after the start edge, and each level SHALL last exactly hp cycles.
REQ-022 Each 1->0 transition of tog_out SHALL increment the period count, with width BURST_W.
REQ-023 If burst_reg != 0, the falling transition completing period burst_reg SHALL also register done=1 and state=IDLE on that same edge.
REQ-024 If burst_reg == 0, RUN SHALL continue until stop; the period count SHALL wrap without effect.
REQ-025 stop sampled in RUN with tog_out=0 SHALL register state=IDLE and done=1 on that edge, leaving tog_out=0.
REQ-026 stop sampled in RUN with tog_out=1 SHALL enter DRAIN, which continues toggling until the next falling transition, then registers IDLE and done=1.
REQ-027 stop in DRAIN SHALL have no further effect.
REQ-028 When stop coincides with burst completion, exactly one done pulse SHALL result.
REQ-029 tog_out SHALL be 0 whenever the state is IDLE.
REQ-030 done SHALL be high for exactly one cycle per completed run.
REQ-031 busy SHALL deassert on the same edge that done asserts.

Reset
REQ-032 rst sampled high SHALL force, on that edge, state=IDLE, tog_out=0, done=0, busy=0, counter=0, period count=0, hp_reg=1, burst_reg=0; cfg_ready SHALL be 1 the following cycle.
REQ-033 rst SHALL override all other inputs, including mid-run, with no done pulse generated.

Verification
REQ-034 Burst run: cfg hp=3, burst=2, then start at edge 0 -> tog_out rises at edge 3, falls at 6, rises at 9, falls at 12 with done=1 at 12 and busy=0 from 12.
REQ-035 Zero half-period: cfg hp=0, burst=1, then start -> tog_out high for 1 cycle and low for 1 cycle, then done.
REQ-036 Stop while high: hp=4, burst=0, stop 1 cycle after first rise -> DRAIN; tog_out falls 4 cycles after that rise, with done that edge and no further toggles.
REQ-037 Stop while low: hp=4, stop 2 cycles after start -> IDLE and done next edge, with tog_out never rising.
REQ-038 Config/start coincidence: cfg hp=5 with start in the same cycle (previous hp=2) -> first rise after 5 cycles; cfg_valid during RUN -> cfg_ready=0, config unchanged.
REQ-039 Reset mid-run: rst asserted while tog_out=1 -> next cycle tog_out=0, busy=0, done=0, cfg_ready=1.
